// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, control-word constants and sequencer state encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_LDB = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_JMP = 8'h05;
  localparam logic [7:0] OP_JZ  = 8'h06;
  localparam logic [7:0] OP_JC  = 8'h07;
  localparam logic [7:0] OP_CLR = 8'h08;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // The {V,N,Z,C} flag set is packed starting at bit 0, so Z sits at bit 2.
  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  localparam logic [31:0] CW_IDLE   = 32'h07FF_58F0;
  localparam logic [31:0] CW_FETCH0 = 32'h0FF7_5870;
  localparam logic [31:0] CW_FETCH1 = 32'h07FF_D8F0;
  localparam logic [31:0] CW_JMP    = 32'h07FF_5AF0;
  localparam logic [31:0] CW_OPADDR = 32'h0FFF_18F0;
  localparam logic [31:0] CW_LDA    = 32'h07F7_50F0;
  localparam logic [31:0] CW_LDB    = 32'h07F7_48F0;
  localparam logic [31:0] CW_ADD    = 32'h07FD_78F0;
  localparam logic [31:0] CW_STA    = 32'h07FB_58B0;
  localparam logic [31:0] CW_CLR    = 32'h07FF_58F8;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_microcode_rom.sv
// ============================================================================
// Module   : microcode_rom
// Brief    : Combinational EXEC-phase table: (opcode, step, flags) -> {last, cw}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [7:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        flags,
  output logic              last,
  output logic [31:0]       cw
);

  logic w_unused_flags;
  assign w_unused_flags = ^{flags[FLAG_V], flags[FLAG_N]};

  // Any step not explicitly listed ends the instruction with an idle word.
  always_comb begin
    last = 1'b1;
    cw   = CW_IDLE;
    case (opcode)
      OP_LDA, OP_LDB, OP_STA: begin
        case (int'(step))
          2: begin
            cw   = CW_OPADDR;
            last = 1'b0;
          end
          3: cw = (opcode == OP_LDA) ? CW_LDA :
                  (opcode == OP_LDB) ? CW_LDB : CW_STA;
          default: ;
        endcase
      end
      OP_ADD: begin
        case (int'(step))
          2: begin
            cw   = CW_OPADDR;
            last = 1'b0;
          end
          3: begin
            cw   = CW_LDB;
            last = 1'b0;
          end
          4: cw = CW_ADD;
          default: ;
        endcase
      end
      OP_JMP: if (int'(step) == 2) cw = CW_JMP;
      OP_JZ:  if (int'(step) == 2 && flags[FLAG_Z]) cw = CW_JMP;
      OP_JC:  if (int'(step) == 2 && flags[FLAG_C]) cw = CW_JMP;
      OP_CLR: if (int'(step) == 2) cw = CW_CLR;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Fetch/execute micro-step sequencer driving the CPU control word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter  int MAX_STEPS = 8,
  localparam int STEP_W    = $clog2(MAX_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        bus_in,
  input  logic [3:0]        flags,
  output logic [31:0]       control_word,
  output logic              ctrlen,
  output logic [STEP_W-1:0] step,
  output logic [7:0]        opcode,
  output logic              halted
);

  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(MAX_STEPS - 1);

  seq_state_t        r_state;
  logic [STEP_W-1:0] r_step;
  logic [7:0]        r_opcode;
  logic              r_halted;
  logic              r_ctrlen;

  logic              w_rom_last;
  logic [31:0]       w_rom_cw;
  logic [31:0]       w_cw;

  microcode_rom #(
    .STEP_W (STEP_W)
  ) u_rom (
    .opcode (r_opcode),
    .step   (r_step),
    .flags  (flags),
    .last   (w_rom_last),
    .cw     (w_rom_cw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RESET;
      r_step   <= '0;
      r_opcode <= 8'h00;
      r_halted <= 1'b0;
      r_ctrlen <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state  <= ST_FETCH;
          r_step   <= '0;
          r_ctrlen <= 1'b1;
        end
        ST_FETCH: begin
          if (run) begin
            if (r_step == '0) begin
              r_opcode <= bus_in;
              r_step   <= STEP_W'(1);
            end else begin
              r_step  <= STEP_W'(2);
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (run) begin
            if (r_opcode == OP_HLT && r_step == STEP_W'(2)) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (w_rom_last || r_step == c_last_step) begin
              r_state <= ST_FETCH;
              r_step  <= '0;
            end else begin
              r_step <= r_step + STEP_W'(1);
            end
          end
        end
        default: ;  // HALT holds everything until reset
      endcase
    end
  end

  // Depends only on registered state and run, so reset forces idle at once.
  always_comb begin
    w_cw = CW_IDLE;
    if (run) begin
      case (r_state)
        ST_FETCH: w_cw = (r_step == '0) ? CW_FETCH0 : CW_FETCH1;
        ST_EXEC:  w_cw = w_rom_cw;
        default:  w_cw = CW_IDLE;
      endcase
    end
  end

  assign control_word = w_cw;
  assign ctrlen       = r_ctrlen;
  assign step         = r_step;
  assign opcode       = r_opcode;
  assign halted       = r_halted;

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 8, meaning micro-steps per instruction including fetch; step counter width is clog2(MAX_STEPS).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port run  input  1  when 1, sequencing advances one step per clk.
REQ-005 SHALL have port bus_in  input  8  main bus value, sampled as opcode at the end of step 0.
REQ-006 SHALL have port flags  input  4  CPU F register {V,N,Z,C}, stable during each step.
REQ-007 SHALL have port control_word  output  32  CPU control word for the current step.
REQ-008 SHALL have port ctrlen  output  1  1 = control_word is valid and driven to the CPU.
REQ-009 SHALL have port step  output  clog2(MAX_STEPS)  current micro-step index.
REQ-010 SHALL have port opcode  output  8  instruction register contents.
REQ-011 SHALL have port halted  output  1  1 once a HLT opcode has executed.

Function
REQ-012 SHALL implement states RESET, FETCH (steps 0-1), EXEC (steps 2..MAX_STEPS-1) and HALT.
REQ-013 SHALL go RESET -> FETCH step 0 on the first clk edge after rst deasserts, regardless of run.
REQ-014 SHALL drive control_word = CW_FETCH0 in step 0 (PC to addr bus, RAM out, IR load) and capture opcode <= bus_in at the edge that ends step 0.
REQ-015 SHALL drive control_word = CW_FETCH1 in step 1 (PC increment), then enter EXEC step 2.
REQ-016 SHALL derive the EXEC control word combinationally from microcode_rom(opcode, step, flags), which returns {last, cw[31:0]}.
REQ-017 SHALL return to FETCH step 0 on the edge ending a step with last=1, and force that return when step = MAX_STEPS-1 even if last=0.
REQ-018 SHALL treat unrecognised opcodes as NOP: step 2 emits CW_IDLE with last=1.
REQ-019 SHALL evaluate conditional jumps (JZ on Z, JC on C) at step 2; condition false emits CW_IDLE with last=1, condition true emits CW_JMP with last=1.
REQ-020 SHALL enter HALT on the edge ending step 2 of opcode 8'hFF, setting halted=1 and control_word=CW_IDLE until reset.
REQ-021 SHALL, while run=0, hold state, step and opcode and output CW_IDLE; resuming with run=1 continues the same step.
REQ-022 SHALL NOT capture opcode when run=0 during step 0.
REQ-023 SHALL drive ctrlen=0 in RESET and ctrlen=1 in FETCH, EXEC and HALT.
REQ-024 SHALL hold CW_IDLE (32'h07FF_58F0) on control_word in RESET and HALT and during any run=0 cycle.

Reset
REQ-025 SHALL, while rst=0, immediately force state=RESET, step=0, opcode=8'h00, halted=0, ctrlen=0 and control_word=CW_IDLE.
REQ-026 SHALL abort any in-flight instruction on rst assertion mid-step without emitting a further non-idle control word.

Structure
REQ-027 SHALL take opcodes (NOP 00, LDA 01, LDB 02, ADD 03, STA 04, JMP 05, JZ 06, JC 07, CLR 08, HLT FF), CW_* constants and the state enum from shared package cpu_ctrl_pkg.
REQ-028 SHALL place the opcode/step/flags to {last, cw} table in one combinational sub-module, microcode_rom.

Verification
REQ-029 SHALL cover reset release with run=1 and bus_in=8'h00: RESET for 1 cycle (ctrlen=0), then steps 0,1,2 emit CW_FETCH0, CW_FETCH1, CW_IDLE, then step returns to 0.
REQ-030 SHALL cover ADD (bus_in=8'h03 at step 0): opcode=8'h03 from step 1, EXEC words equal the ROM entries, then back to step 0.
REQ-031 SHALL cover JZ with flags=4'b0100 -> step 2 emits CW_JMP, and with flags=4'b0000 -> step 2 emits CW_IDLE; both return to step 0 next cycle.
REQ-032 SHALL cover run=0 held for 3 cycles at step 3 of ADD: step stays 3, control_word=CW_IDLE, and after run=1 the step-3 word resumes.
REQ-033 SHALL cover HLT (8'hFF): halted=1 after step 2, control_word=CW_IDLE and step frozen for 10 cycles, and rst=0 then 1 restarts the fetch.
REQ-034 SHALL cover rst asserted asynchronously mid-EXEC between clk edges: outputs take reset values at once, before the next clk edge.
